// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation tags and the multiply sequencer state encoding.
// Imported by the decoder, the execute-stage mux and the multiply sequencer.
package alu_pkg;

  typedef logic [3:0] alu_tag_t;

  localparam alu_tag_t ALU_AND  = 4'b0000;
  localparam alu_tag_t ALU_ORR  = 4'b0001;
  localparam alu_tag_t ALU_ADD  = 4'b0010;
  localparam alu_tag_t ALU_LSL  = 4'b0011;
  localparam alu_tag_t ALU_LSR  = 4'b0100;
  localparam alu_tag_t ALU_PASS = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Bundle between the multiply sequencer, its requester/consumer and the shared ALU.
// The slave side is the sequencer; the master side is the requester plus the ALU.
interface alu_mul_seq_if #(
  parameter int WIDTH = 64
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_prod;

  logic             busy;
  logic [WIDTH-1:0] alu_r1;
  logic [WIDTH-1:0] alu_r2;
  alu_tag_t         alu_tag;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, alu_out, alu_zero,
    output in_ready, out_valid, out_prod, busy, alu_r1, alu_r2, alu_tag
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, alu_out, alu_zero,
    input  in_ready, out_valid, out_prod, busy, alu_r1, alu_r2, alu_tag
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU for every add and shift.
// Produces the low WIDTH bits of a*b; owns the ALU only while busy is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          reset,
  alu_mul_seq_if.slave bus
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Stop once the shifted multiplier has no set bits left, or after the last bit.
  assign last_iter = bus.alu_zero || (cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_prod  = '0;
    bus.busy      = 1'b0;
    bus.alu_tag   = ALU_PASS;
    bus.alu_r1    = '0;
    bus.alu_r2    = '0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = S_ADD;
      end
      S_ADD: begin
        bus.busy    = 1'b1;
        bus.alu_tag = ALU_ADD;
        bus.alu_r1  = acc;
        bus.alu_r2  = mcand;
        state_d     = S_SHL;
      end
      S_SHL: begin
        bus.busy    = 1'b1;
        bus.alu_tag = ALU_LSL;
        bus.alu_r1  = mcand;
        bus.alu_r2  = ONE;
        state_d     = S_SHR;
      end
      S_SHR: begin
        bus.busy    = 1'b1;
        bus.alu_tag = ALU_LSR;
        bus.alu_r1  = mplier;
        bus.alu_r2  = ONE;
        state_d     = last_iter ? DONE : S_ADD;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_prod  = acc;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: each state commits the ALU result it requested this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= bus.in_a;
            mplier <= bus.in_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_ADD: begin
          if (mplier[0]) acc <= bus.alu_out;
        end
        S_SHL: mcand <= bus.alu_out;
        S_SHR: begin
          mplier <= bus.alu_out;
          if (!last_iter) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed corner cases plus randomized products, with a
// behavioural ALU and a reference computed from plain 64-bit arithmetic.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared execute-stage ALU.
  always_comb begin
    case (bus.alu_tag)
      ALU_AND: bus.alu_out = bus.alu_r1 & bus.alu_r2;
      ALU_ORR: bus.alu_out = bus.alu_r1 | bus.alu_r2;
      ALU_ADD: bus.alu_out = bus.alu_r1 + bus.alu_r2;
      ALU_LSL: bus.alu_out = bus.alu_r1 << bus.alu_r2[5:0];
      ALU_LSR: bus.alu_out = bus.alu_r1 >> bus.alu_r2[5:0];
      default: bus.alu_out = bus.alu_r1;
    endcase
    bus.alu_zero = (bus.alu_out == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [63:0] b);
    int m = 0;
    for (int i = 0; i < 64; i++) if (b[i]) m = i + 1;
    if (m == 0) m = 1;
    return 3 * m + 1;
  endfunction

  // Called just after a falling edge; returns just after a falling edge with the
  // DUT back in IDLE. Holds out_ready low for 'hold' cycles once DONE is reached.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int hold,
                        input string name);
    int          cyc;
    int          step;
    int          it;
    bit          seen;
    logic [63:0] prod;
    logic [63:0] mask;

    prod = a * b;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, ".accept_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = {$urandom, $urandom};
    bus.in_b     = {$urandom, $urandom};

    seen = 1'b0;
    for (cyc = 1; cyc <= 250; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      step = cyc - 1;
      it   = step / 3;
      mask = (64'd1 << it) - 64'd1;
      check({name, ".busy"}, 64'(bus.busy), 64'd1);
      check({name, ".in_ready_low"}, 64'(bus.in_ready), 64'd0);
      case (step % 3)
        0: begin
          check({name, ".tag_add"}, 64'(bus.alu_tag), 64'(ALU_ADD));
          check({name, ".add_acc"}, bus.alu_r1, a * (b & mask));
          check({name, ".add_mcand"}, bus.alu_r2, a << it);
        end
        1: begin
          check({name, ".tag_lsl"}, 64'(bus.alu_tag), 64'(ALU_LSL));
          check({name, ".lsl_r1"}, bus.alu_r1, a << it);
          check({name, ".lsl_r2"}, bus.alu_r2, 64'd1);
        end
        default: begin
          check({name, ".tag_lsr"}, 64'(bus.alu_tag), 64'(ALU_LSR));
          check({name, ".lsr_r1"}, bus.alu_r1, b >> it);
          check({name, ".lsr_r2"}, bus.alu_r2, 64'd1);
        end
      endcase
    end
    check({name, ".latency"}, seen ? 64'(cyc) : 64'd0, 64'(exp_latency(b)));
    check({name, ".prod"}, bus.out_prod, prod);
    check({name, ".done_busy"}, 64'(bus.busy), 64'd0);
    check({name, ".done_tag"}, 64'(bus.alu_tag), 64'(ALU_PASS));

    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = {$urandom, $urandom};
      @(negedge clk);
      check({name, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, ".hold_prod"}, bus.out_prod, prod);
      check({name, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, ".release_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, ".release_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.out_prod", bus.out_prod, 64'd0);
    check("rst.tag", 64'(bus.alu_tag), 64'(ALU_PASS));
    check("rst.r1", bus.alu_r1, 64'd0);
    check("rst.r2", bus.alu_r2, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(64'd3, 64'd5, 0, "mul3x5");
    run_op(64'h1234, 64'd0, 0, "b_zero");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, "wrap");
    run_op(64'd1, 64'h8000_0000_0000_0000, 0, "msb");
    run_op(64'd7, 64'd6, 5, "backpressure");
    run_op(64'd9, 64'd10, 0, "back2back");

    // Abort a run in S_SHL with an asynchronous reset.
    bus.in_a     = 64'd9;
    bus.in_b     = 64'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.in_shl", 64'(bus.alu_tag), 64'(ALU_LSL));
    reset = 1'b1;
    #1;
    check("abort.out_valid", 64'(bus.out_valid), 64'd0);
    check("abort.in_ready", 64'(bus.in_ready), 64'd1);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.tag", 64'(bus.alu_tag), 64'(ALU_PASS));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort.no_valid", 64'(bus.out_valid), 64'd0);
    run_op(64'd2, 64'd3, 0, "after_abort");

    for (int n = 0; n < 20; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
